// File: rtl/reg_write_arbiter.sv
// Four-requester round-robin arbiter writing a shared register, with optional
// locked bursts of up to MAX_BURST back-to-back grants to one requester.
module reg_write_arbiter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req,
   input  logic [3:0]       lock,
   input  logic [WIDTH-1:0] wdata0,
   input  logic [WIDTH-1:0] wdata1,
   input  logic [WIDTH-1:0] wdata2,
   input  logic [WIDTH-1:0] wdata3,
   output logic [3:0]       gnt,
   output logic             load_out,
   output logic [WIDTH-1:0] data_out,
   output logic [1:0]       owner,
   output logic             busy
);

   typedef enum logic {IDLE, LOCKED} state_t;

   localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

   state_t           state, state_nx;
   logic [1:0]       ptr, ptr_nx;
   logic [3:0]       cnt, cnt_nx;
   logic [3:0]       gnt_nx;
   logic             load_nx;
   logic [WIDTH-1:0] data_nx;
   logic [1:0]       owner_nx;
   logic             found;
   logic [1:0]       win;
   logic             stay_locked;

   function automatic logic [WIDTH-1:0] sel_data(input logic [1:0] i);
      case (i)
         2'd0:    return wdata0;
         2'd1:    return wdata1;
         2'd2:    return wdata2;
         default: return wdata3;
      endcase
   endfunction

   // First requester found scanning from ptr upward, wrapping mod 4.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         if (!found && req[ptr + 2'(k)]) begin
            found = 1'b1;
            win   = ptr + 2'(k);
         end
      end
   end

   assign stay_locked = (state == LOCKED) && req[owner] && lock[owner] && (cnt < MAX_CNT);

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      cnt_nx   = cnt;
      gnt_nx   = '0;
      load_nx  = 1'b0;
      data_nx  = data_out;
      owner_nx = owner;
      if (stay_locked) begin
         data_nx = sel_data(owner);
         gnt_nx  = 4'b0001 << owner;
         load_nx = 1'b1;
         cnt_nx  = cnt + 4'd1;
      end else begin
         // Leaving a burst arbitrates on the same edge, but never re-locks on it.
         state_nx = IDLE;
         if (found) begin
            data_nx  = sel_data(win);
            gnt_nx   = 4'b0001 << win;
            load_nx  = 1'b1;
            owner_nx = win;
            ptr_nx   = win + 2'd1;
            if ((state == IDLE) && lock[win] && (MAX_BURST > 1)) begin
               state_nx = LOCKED;
               cnt_nx   = 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= '0;
         cnt      <= '0;
         gnt      <= '0;
         load_out <= 1'b0;
         data_out <= '0;
         owner    <= '0;
      end else begin
         state    <= state_nx;
         ptr      <= ptr_nx;
         cnt      <= cnt_nx;
         gnt      <= gnt_nx;
         load_out <= load_nx;
         data_out <= data_nx;
         owner    <= owner_nx;
      end
   end

   assign busy = (state == LOCKED);

endmodule
